// File: rtl/logcmp_issue.sv
// In-order issue queue for the logic/compare unit: buffers dispatched micro-ops,
// waits for source writeback, and emits one registered execute packet per cycle.
module logcmp_issue #(
  parameter int DEPTH = 4,
  parameter int RNBIT = 2
) (
  input  logic                                CLK,
  input  logic                                RSTn,
  input  logic                                flush,
  input  logic                                dispat_logCmp_valid,
  output logic                                logCmp_issue_ready,
  input  logic [70+3*(5+RNBIT)-1:0]           dispat_logCmp_info,
  input  logic [64*(1<<(5+RNBIT))-1:0]        regFileX_read,
  input  logic [(1<<(5+RNBIT))-1:0]           wbLog,
  output logic                                logCmp_execute_vaild,
  output logic [138+RNBIT-1:0]                logCmp_execute_info
);

  localparam int PW = 5 + RNBIT;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = 70 + 3*PW;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [IW-1:0] entries [DEPTH];
  logic [AW:0]   rdPtr;
  logic [AW:0]   wrPtr;

  logic [IW-1:0] head;
  logic [63:0]   headImm;
  logic [PW-1:0] headRs1;
  logic [PW-1:0] headRs2;
  logic [PW-1:0] headRd;
  logic          headIsImm;
  logic          headIsUsi;
  logic [3:0]    headFun;

  logic          rs1Zero;
  logic          rs2Zero;
  logic          rs1Ready;
  logic          rs2Ready;
  logic [63:0]   op1;
  logic [63:0]   op2;
  logic          empty;
  logic          full;
  logic          doIssue;
  logic          doEnq;

  // Entry layout: {fun[3:0], isUsi, isImm, rd0, rs1, rs2, imm[63:0]}
  assign head      = entries[rdPtr[AW-1:0]];
  assign headImm   = head[63:0];
  assign headRs2   = head[64 +: PW];
  assign headRs1   = head[64+PW +: PW];
  assign headRd    = head[64+2*PW +: PW];
  assign headIsImm = head[64+3*PW];
  assign headIsUsi = head[65+3*PW];
  assign headFun   = head[66+3*PW +: 4];

  // Architectural x0 reads as zero regardless of its rename bits.
  assign rs1Zero  = (headRs1[PW-1:RNBIT] == '0);
  assign rs2Zero  = (headRs2[PW-1:RNBIT] == '0);
  assign rs1Ready = rs1Zero | wbLog[headRs1];
  assign rs2Ready = headIsImm | rs2Zero | wbLog[headRs2];

  assign op1 = rs1Zero ? 64'd0 : regFileX_read[{headRs1, 6'd0} +: 64];
  assign op2 = headIsImm ? headImm :
               (rs2Zero ? 64'd0 : regFileX_read[{headRs2, 6'd0} +: 64]);

  assign empty = (rdPtr == wrPtr);
  assign full  = (rdPtr[AW] != wrPtr[AW]) && (rdPtr[AW-1:0] == wrPtr[AW-1:0]);

  assign logCmp_issue_ready = RSTn & ~full;
  assign doIssue = ~empty & rs1Ready & rs2Ready & ~flush;
  assign doEnq   = dispat_logCmp_valid & logCmp_issue_ready & ~flush;

  always_ff @(posedge CLK) begin
    if (doEnq) begin
      entries[wrPtr[AW-1:0]] <= dispat_logCmp_info;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      rdPtr                <= '0;
      wrPtr                <= '0;
      logCmp_execute_vaild <= 1'b0;
      logCmp_execute_info  <= '0;
    end else if (flush) begin
      rdPtr                <= '0;
      wrPtr                <= '0;
      logCmp_execute_vaild <= 1'b0;
    end else begin
      logCmp_execute_vaild <= doIssue;
      if (doIssue) begin
        rdPtr               <= rdPtr + PTR_ONE;
        logCmp_execute_info <= {headFun, headRd, op1, op2, headIsUsi};
      end
      if (doEnq) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_logcmp_issue.sv
// Directed bench for logcmp_issue: single-op vector table plus hand-written
// stall, full/wrap, flush and reset sequences.
module tb_logcmp_issue;

  localparam int DEPTH = 4;
  localparam int RNBIT = 2;
  localparam int NREG  = 128;
  localparam int IW    = 91;
  localparam int OW    = 140;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              flush = 1'b0;
  logic              dValid = 1'b0;
  logic [IW-1:0]     dInfo = '0;
  logic [64*NREG-1:0] rf;
  logic [NREG-1:0]   wb = '1;
  logic              ready;
  logic              vaild;
  logic [OW-1:0]     info;

  int nChecks = 0;
  int nFail   = 0;

  always #5 CLK = ~CLK;

  logcmp_issue #(.DEPTH(DEPTH), .RNBIT(RNBIT)) dut (
    .CLK                  (CLK),
    .RSTn                 (RSTn),
    .flush                (flush),
    .dispat_logCmp_valid  (dValid),
    .logCmp_issue_ready   (ready),
    .dispat_logCmp_info   (dInfo),
    .regFileX_read        (rf),
    .wbLog                (wb),
    .logCmp_execute_vaild (vaild),
    .logCmp_execute_info  (info)
  );

  typedef struct {
    logic [3:0]  fun;
    logic        isUsi;
    logic        isImm;
    logic [6:0]  rd;
    logic [6:0]  rs1;
    logic [6:0]  rs2;
    logic [63:0] imm;
    logic        wbAll;
    logic [63:0] expOp1;
    logic [63:0] expOp2;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] pack(input logic [3:0] fun, input logic isUsi, input logic isImm,
                                         input logic [6:0] rd, input logic [6:0] rs1,
                                         input logic [6:0] rs2, input logic [63:0] imm);
    return {fun, isUsi, isImm, rd, rs1, rs2, imm};
  endfunction

  function automatic logic [OW-1:0] pkt(input logic [3:0] fun, input logic [6:0] rd,
                                        input logic [63:0] op1, input logic [63:0] op2,
                                        input logic isUsi);
    return {fun, rd, op1, op2, isUsi};
  endfunction

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic offer(input logic [IW-1:0] x);
    dInfo  = x;
    dValid = 1'b1;
  endtask

  function automatic logic [OW-1:0] rdOf(input logic [OW-1:0] p);
    return OW'(p[135:129]);
  endfunction

  // Fill the queue behind an unready head, offer a fifth op, then drain in order.
  task automatic fullRound(input logic [6:0] base);
    logic [6:0] rd;
    wb[29] = 1'b0;
    check("full_ready_start", OW'(ready), OW'(1'b1));
    for (int k = 0; k < 4; k++) begin
      rd = 7'(int'(base) + k);
      offer(pack(4'b0001, 1'b0, 1'b0, rd, 7'd6, 7'd29, 64'd0));
      tick();
    end
    check("full_ready_low", OW'(ready), OW'(1'b0));
    rd = 7'(int'(base) + 4);
    offer(pack(4'b0100, 1'b1, 1'b1, rd, 7'd6, 7'd0, 64'h77));
    tick();
    check("full_ready_hold", OW'(ready), OW'(1'b0));
    check("full_no_issue", OW'(vaild), OW'(1'b0));
    wb[29] = 1'b1;
    tick();
    check("full_drain0_v", OW'(vaild), OW'(1'b1));
    check("full_drain0_rd", rdOf(info), OW'(base));
    check("full_ready_back", OW'(ready), OW'(1'b1));
    tick();
    dValid = 1'b0;
    check("full_drain1_rd", rdOf(info), OW'(7'(int'(base) + 1)));
    for (int j = 2; j < 5; j++) begin
      tick();
      check("full_drain_v", OW'(vaild), OW'(1'b1));
      check("full_drain_rd", rdOf(info), OW'(7'(int'(base) + j)));
    end
    check("full_fifth_pkt", info, pkt(4'b0100, 7'(int'(base) + 4), 64'hABCD_0000_0000_0006, 64'h77, 1'b1));
    tick();
    check("full_drain_end", OW'(vaild), OW'(1'b0));
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) rf[64*i +: 64] = {56'hABCD_0000_0000_00, 8'(i)};
    rf[64*12 +: 64] = 64'h5;

    vecs[0] = '{fun:4'b0100, isUsi:1'b0, isImm:1'b1, rd:7'h2A, rs1:7'd12, rs2:7'd29,
                imm:64'hFFFF_FFFF_FFFF_FFFF, wbAll:1'b1,
                expOp1:64'h5, expOp2:64'hFFFF_FFFF_FFFF_FFFF};
    vecs[1] = '{fun:4'b0001, isUsi:1'b0, isImm:1'b0, rd:7'h11, rs1:7'd6, rs2:7'd29,
                imm:64'd0, wbAll:1'b1,
                expOp1:64'hABCD_0000_0000_0006, expOp2:64'hABCD_0000_0000_001D};
    vecs[2] = '{fun:4'b1000, isUsi:1'b1, isImm:1'b0, rd:7'h05, rs1:7'd3, rs2:7'd1,
                imm:64'h1234, wbAll:1'b0,
                expOp1:64'd0, expOp2:64'd0};
    vecs[3] = '{fun:4'b0010, isUsi:1'b1, isImm:1'b1, rd:7'h7F, rs1:7'd127, rs2:7'h50,
                imm:64'h0123_4567_89AB_CDEF, wbAll:1'b1,
                expOp1:64'hABCD_0000_0000_007F, expOp2:64'h0123_4567_89AB_CDEF};
    vecs[4] = '{fun:4'b1000, isUsi:1'b0, isImm:1'b0, rd:7'h33, rs1:7'd64, rs2:7'd2,
                imm:64'hFFFF, wbAll:1'b1,
                expOp1:64'hABCD_0000_0000_0040, expOp2:64'd0};

    // Reset state
    tick(); tick();
    check("rst_vaild", OW'(vaild), OW'(1'b0));
    check("rst_info", info, '0);
    check("rst_ready", OW'(ready), OW'(1'b0));
    RSTn = 1'b1;
    #1;
    check("rel_ready", OW'(ready), OW'(1'b1));
    tick();

    // Single-op vectors: latency 2, full packet compare
    for (int i = 0; i < 5; i++) begin
      wb = vecs[i].wbAll ? '1 : '0;
      offer(pack(vecs[i].fun, vecs[i].isUsi, vecs[i].isImm, vecs[i].rd,
                 vecs[i].rs1, vecs[i].rs2, vecs[i].imm));
      tick();
      dValid = 1'b0;
      check("vec_lat1", OW'(vaild), OW'(1'b0));
      tick();
      check("vec_vaild", OW'(vaild), OW'(1'b1));
      check("vec_pkt", info, pkt(vecs[i].fun, vecs[i].rd, vecs[i].expOp1, vecs[i].expOp2, vecs[i].isUsi));
      tick();
      check("vec_once", OW'(vaild), OW'(1'b0));
    end
    wb = '1;

    // Dependency stall with a younger ready op behind
    wb[29] = 1'b0;
    offer(pack(4'b0001, 1'b0, 1'b0, 7'h01, 7'd6, 7'd29, 64'd0));
    tick();
    offer(pack(4'b0010, 1'b0, 1'b1, 7'h02, 7'd6, 7'd0, 64'h5));
    tick();
    dValid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("stall_hold", OW'(vaild), OW'(1'b0));
      tick();
    end
    wb[29] = 1'b1;
    tick();
    check("stall_a", info, pkt(4'b0001, 7'h01, 64'hABCD_0000_0000_0006, 64'hABCD_0000_0000_001D, 1'b0));
    check("stall_a_v", OW'(vaild), OW'(1'b1));
    tick();
    check("stall_b", info, pkt(4'b0010, 7'h02, 64'hABCD_0000_0000_0006, 64'h5, 1'b0));
    check("stall_b_v", OW'(vaild), OW'(1'b1));
    tick();
    check("stall_end", OW'(vaild), OW'(1'b0));

    // Full / back-pressure, twice to cross the pointer wrap
    fullRound(7'h10);
    fullRound(7'h20);

    // Flush with three entries, ready head and an offered dispatch
    wb[29] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      offer(pack(4'b0001, 1'b0, 1'b0, 7'(8'h30 + k), 7'd6, 7'd29, 64'd0));
      tick();
    end
    offer(pack(4'b0100, 1'b0, 1'b1, 7'h33, 7'd6, 7'd0, 64'h9));
    wb[29] = 1'b1;
    flush  = 1'b1;
    tick();
    flush  = 1'b0;
    dValid = 1'b0;
    check("flush_vaild", OW'(vaild), OW'(1'b0));
    check("flush_ready", OW'(ready), OW'(1'b1));
    for (int c = 0; c < 4; c++) begin
      tick();
      check("flush_empty", OW'(vaild), OW'(1'b0));
    end
    offer(pack(4'b0100, 1'b0, 1'b1, 7'h34, 7'd6, 7'd0, 64'h9));
    tick();
    dValid = 1'b0;
    tick();
    check("flush_next_v", OW'(vaild), OW'(1'b1));
    check("flush_next_rd", rdOf(info), OW'(7'h34));
    tick();
    check("flush_next_end", OW'(vaild), OW'(1'b0));

    // Reset mid-stream
    wb[29] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      offer(pack(4'b0001, 1'b0, 1'b0, 7'(8'h40 + k), 7'd6, 7'd29, 64'd0));
      tick();
    end
    dValid = 1'b0;
    wb[29] = 1'b1;
    tick();
    check("mid_v", OW'(vaild), OW'(1'b1));
    check("mid_rd", rdOf(info), OW'(7'h40));
    RSTn = 1'b0;
    tick();
    check("mid_rst_vaild", OW'(vaild), OW'(1'b0));
    check("mid_rst_info", info, '0);
    check("mid_rst_ready", OW'(ready), OW'(1'b0));
    tick();
    check("mid_rst_ready2", OW'(ready), OW'(1'b0));
    RSTn = 1'b1;
    #1;
    check("mid_rel_ready", OW'(ready), OW'(1'b1));
    for (int c = 0; c < 4; c++) begin
      tick();
      check("mid_no_stale", OW'(vaild), OW'(1'b0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/logcmp_issue.md
# logcmp_issue

In-order issue queue for the logic/compare execution unit. It buffers logic/compare micro-ops from dispatch, waits until their source physical registers are written back, and reads the operand values. It then emits one registered, packed execute packet per cycle to the single-cycle logic/compare unit, which consumes the packet without back-pressure.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2
- RNBIT, 2, rename bits per architectural register; physical index = {arch[4:0], rename[RNBIT-1:0]}, width 5+RNBIT

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RSTn  in  1  reset, synchronous, active-low
- flush  in  1  pipeline flush; empties queue and drops output packet
- dispat_logCmp_valid  in  1  dispatch offers a micro-op
- logCmp_issue_ready  out  1  queue can accept; equals ~full, 0 while RSTn low
- dispat_logCmp_info  in  70+3*(5+RNBIT)  {fun_slt, fun_xor, fun_or, fun_and, isUsi, isImm, rd0, rs1, rs2, imm[63:0]}
- regFileX_read  in  64*2^(5+RNBIT)  flat physical register file; entry i at bits [64*i+63:64*i]
- wbLog  in  2^(5+RNBIT)  bit i = 1 when physical register i holds its final value
- logCmp_execute_vaild  out  1  registered; packet valid for exactly one cycle
- logCmp_execute_info  out  138+RNBIT  registered {fun_slt, fun_xor, fun_or, fun_and, rd0, op1[63:0], op2[63:0], isUsi}

## Operation
- Storage: circular FIFO of DEPTH entries. rd_ptr and wr_ptr are log2(DEPTH)+1 bits wide. empty = (rd_ptr == wr_ptr). full = MSBs differ and the low bits are equal.
- Enqueue: dispat_logCmp_valid & logCmp_issue_ready & ~flush writes the entry at wr_ptr, then wr_ptr+1.
- Operand readiness for head entry:
  - rs1 is ready when rs1[4+RNBIT:RNBIT] == 0 (x0) or wbLog[rs1] == 1.
  - rs2 is ready when isImm == 1, rs2 arch == 0, or wbLog[rs2] == 1.
- Operand values:
  - op1 = 0 if rs1 arch == 0, else regFileX_read[rs1].
  - op2 = imm if isImm == 1; otherwise 0 if rs2 arch == 0, else regFileX_read[rs2].
  - Values are sampled in the issue cycle.
- Issue: when ~empty & both operands ready & ~flush, register the packet into logCmp_execute_info, set logCmp_execute_vaild = 1, and advance rd_ptr. Otherwise logCmp_execute_vaild = 0 and logCmp_execute_info holds its previous value.
- Strict in-order: a non-ready head blocks younger ready entries.
- Exactly one fun bit is set per micro-op. The queue passes fun bits through without checking them.
- Simultaneous enqueue and issue in one cycle is legal and leaves the count unchanged.
- ready is computed from the current-cycle full only; there is no same-cycle pass-through of a slot freed by issue.
- flush (with RSTn high): rd_ptr = wr_ptr = 0 and logCmp_execute_vaild = 0 next cycle. A dispatch offered in the flush cycle is dropped. flush overrides issue and enqueue.
- Reset (RSTn low at an edge): pointers 0, logCmp_execute_vaild 0, logCmp_execute_info 0. Entry payloads are don't-care. Reset mid-operation discards all entries.

## Timing
- Enqueue at edge N makes the entry visible at the head during cycle N+1 if the queue was empty. The earliest logCmp_execute_vaild is high in cycle N+2 (dispatch-to-execute latency 2).
- Throughput: 1 issue/cycle while the head stays ready.
- wbLog/regFileX_read are combinational inputs. A bit rising in cycle M permits issue at edge M, with the packet visible in M+1.
- After reset release, logCmp_issue_ready = 1 in the first cycle with RSTn high.
- Full: after DEPTH enqueues without issue, ready = 0 from the next cycle. It returns to 1 the cycle after the first issue.
- Pointer wrap: low bits roll from DEPTH-1 to 0 and MSB toggles. FIFO order is preserved across the wrap.

## Test plan
- Immediate op: rs1 = {5'd3,2'd0} with wbLog=1, reg = 64'h5, isImm=1, imm=64'hFFFF_FFFF_FFFF_FFFF, fun_xor → vaild high 2 cycles after dispatch; op1=5, op2=all-ones, rd0 passed through unchanged.
- Dependency stall: rs2 wbLog=0 for 5 cycles, then 1 → no issue while 0; packet appears the cycle after wbLog rises; a younger ready op issues only on the following cycle.
- x0 sources: rs1 arch=0, rs2 arch=0, wbLog all 0, fun_slt, isUsi=1 → issues without stall; op1=op2=0, isUsi=1.
- Full/back-pressure with DEPTH=4: hold head unready and dispatch 5 ops → ready drops after 4th; release head → 4 packets on consecutive cycles in dispatch order, then 5th accepted. Repeat past pointer wrap and check order.
- Flush: queue holds 3 entries with head ready and a dispatch offered, flush=1 for one cycle → vaild=0 next cycle, queue empty, the offered op is never issued, ready=1.
- Reset mid-stream: assert RSTn=0 with 2 entries queued and vaild=1 → next cycle vaild=0, info=0, ready=0 during reset; after release no stale packets are issued.
